// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   n_digits  : number of DIGIT-wide steps needed to cover WIDTH bits
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_subtractor_slice.sv
// fs_slice: combinational ripple of DIGIT full-subtractor cells.
//   x, y       : DIGIT-bit minuend / subtrahend digits (LSB = cell 0)
//   bi         : borrow into cell 0
//   d          : DIGIT-bit difference
//   bo         : borrow out of the top cell
//   bo_msb_in  : borrow into the top cell (the top-cell carry-in for overflow)
module fs_slice
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo,
  output logic             bo_msb_in
);

  // brw[i] is the borrow into cell i; brw[DIGIT] leaves the slice.
  logic [DIGIT:0] brw;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    brw    = '0;
    d      = '0;
    brw[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]       = x[i] ^ y[i] ^ brw[i];
      // Borrow when x < y, or when x == y and a borrow is already pending.
      brw[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
    end
  end

  assign bo        = brw[DIGIT];
  assign bo_msb_in = brw[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle diff = a - b - bin, DIGIT bits per clock, LSB first.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request, accepted whenever busy == 0 (IDLE or DONE)
//   a, b, bin  : operands, sampled on an accepted start
//   busy       : high while digits are being processed
//   done       : one-cycle pulse, results valid
//   diff       : a - b - bin mod 2^WIDTH
//   bout       : borrow out of the MSB (unsigned a < b + bin)
//   ovf        : signed overflow (borrow into MSB xor borrow out of MSB)
//   zero       : diff == 0
// Result outputs change only on the edge that enters DONE and hold until the
// next completion.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = n_digits(WIDTH, DIGIT);
  localparam int CNT_W = $clog2(N) + 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: DIGIT must be 1..WIDTH and divide WIDTH");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_nxt;
  logic             brw_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, last;

  logic [DIGIT-1:0] slice_d;
  logic             slice_bo, slice_bo_msb_in;

  fs_slice #(.DIGIT(DIGIT)) u_slice (
    .x         (a_sh[DIGIT-1:0]),
    .y         (b_sh[DIGIT-1:0]),
    .bi        (brw_q),
    .d         (slice_d),
    .bo        (slice_bo),
    .bo_msb_in (slice_bo_msb_in)
  );

  // Start is honoured in IDLE and in DONE (back-to-back), never during RUN.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CNT_W'(N - 1));

  // New digit enters at the MSB end; after N steps the first digit sits at the LSBs.
  assign diff_nxt = (diff_sh >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the operand/shift registers are reset along with the result flops;
  // they are few flops and a reset keeps simulation free of X at power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw_q   <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      brw_q   <= bin;
      diff_sh <= '0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> DIGIT;
      b_sh    <= b_sh >> DIGIT;
      diff_sh <= diff_nxt;
      brw_q   <= slice_bo;
      cnt     <= cnt + CNT_W'(1);
      if (last) begin
        diff <= diff_nxt;
        bout <= slice_bo;
        ovf  <= slice_bo ^ slice_bo_msb_in;
        zero <= (diff_nxt == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 with DIGIT 1/2/4/8 and
// WIDTH=4 with DIGIT 1/2/4. Instance g_w8[0] (DIGIT=1) carries the directed
// handshake tests; the others join the reference-model sweeps.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic [3:0] d8_busy, d8_done, d8_bout, d8_ovf, d8_zero;
  logic [7:0] d8_diff [4];

  logic       start4, bin4;
  logic [3:0] a4, b4;
  logic [2:0] d4_busy, d4_done, d4_bout, d4_ovf, d4_zero;
  logic [3:0] d4_diff [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_w8
    serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .bin   (bin8),
      .busy  (d8_busy[g]),
      .done  (d8_done[g]),
      .diff  (d8_diff[g]),
      .bout  (d8_bout[g]),
      .ovf   (d8_ovf[g]),
      .zero  (d8_zero[g])
    );
  end

  for (genvar g = 0; g < 3; g++) begin : g_w4
    serial_subtractor #(.WIDTH(4), .DIGIT(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .bin   (bin4),
      .busy  (d4_busy[g]),
      .done  (d4_done[g]),
      .diff  (d4_diff[g]),
      .bout  (d4_bout[g]),
      .ovf   (d4_ovf[g]),
      .zero  (d4_zero[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges after the accepting edge until done (bounded at 20).
  task automatic wait_done8(output int lat);
    lat = 0;
    while (d8_done[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic bi, input logic [7:0] e_diff, input logic e_bout,
                     input logic e_ovf, input logic e_zero);
    int lat;
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, " busy"}, 32'(d8_busy[0]), 32'd1);
    wait_done8(lat);
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " busy@done"}, 32'(d8_busy[0]), 32'd0);
    check({tag, " diff"}, 32'(d8_diff[0]), 32'(e_diff));
    check({tag, " bout"}, 32'(d8_bout[0]), 32'(e_bout));
    check({tag, " ovf"}, 32'(d8_ovf[0]), 32'(e_ovf));
    check({tag, " zero"}, 32'(d8_zero[0]), 32'(e_zero));
    tick();
    check({tag, " done pulse"}, 32'(d8_done[0]), 32'd0);
  endtask

  initial begin
    int lat, lat2, seen;
    int n, sa, sb, s;
    logic [8:0] r9;
    logic [4:0] r5;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #13;
    check("reset busy", 32'(d8_busy[0]), 32'd0);
    check("reset done", 32'(d8_done[0]), 32'd0);
    check("reset diff", 32'(d8_diff[0]), 32'd0);
    check("reset flags", 32'({d8_bout[0], d8_ovf[0], d8_zero[0]}), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Basic, borrow, signed overflow and zero cases.
    op8("t1 05-03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    op8("t2 03-05",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    op8("t2 80-01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("t3 00-FF-1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("t3 FF-FF",   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    op8("t1b 5A-3C-1", 8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0, 1'b0, 1'b0);

    // Start pulses during a run are ignored; result stays on the first operands.
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
      tick();
    end
    start8 = 1'b0;
    check("t4 diff held mid-run", 32'(d8_diff[0]), 32'h1D);
    check("t4 busy mid-run", 32'(d8_busy[0]), 32'd1);
    wait_done8(lat);
    check("t4 latency", 32'(4 + lat), 32'd8);
    check("t4 diff", 32'(d8_diff[0]), 32'h02);
    tick();
    check("t4 no requeue", 32'({d8_busy[0], d8_done[0]}), 32'd0);

    // Start held high through DONE: back-to-back second operation.
    a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h40; b8 = 8'h02;
    wait_done8(lat);
    check("t4b first latency", 32'(lat), 32'd8);
    check("t4b first diff", 32'(d8_diff[0]), 32'h1F);
    tick();
    start8 = 1'b0;
    check("t4b rerun busy", 32'(d8_busy[0]), 32'd1);
    check("t4b rerun done low", 32'(d8_done[0]), 32'd0);
    check("t4b diff held", 32'(d8_diff[0]), 32'h1F);
    wait_done8(lat2);
    check("t4b done spacing", 32'(lat2 + 1), 32'd9);
    check("t4b second diff", 32'(d8_diff[0]), 32'h3E);

    // Reset mid-operation.
    tick();
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t5 busy in reset", 32'(d8_busy[0]), 32'd0);
    check("t5 done in reset", 32'(d8_done[0]), 32'd0);
    check("t5 diff in reset", 32'(d8_diff[0]), 32'd0);
    check("t5 flags in reset", 32'({d8_bout[0], d8_ovf[0], d8_zero[0]}), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (d8_done[0] === 1'b1 || d8_busy[0] === 1'b1) seen++;
    end
    check("t5 no done after abort", 32'(seen), 32'd0);
    op8("t5 10-01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    // WIDTH=4 exhaustive, DIGIT 1/2/4, with per-cycle latency check.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
          r5 = 5'(ai) - 5'(bi) - 5'(ci);
          sa = (ai >= 8) ? ai - 16 : ai;
          sb = (bi >= 8) ? bi - 16 : bi;
          s  = sa - sb - ci;
          tick();
          start4 = 1'b0;
          for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
              n = 4 >> g;
              check($sformatf("w4 d%0d %0h-%0h-%0d done@%0d", 1 << g, ai, bi, ci, cyc),
                    32'(d4_done[g]), 32'(cyc == n));
              if (cyc == n) begin
                check($sformatf("w4 d%0d %0h-%0h-%0d res", 1 << g, ai, bi, ci),
                      32'({d4_diff[g], d4_bout[g], d4_ovf[g], d4_zero[g]}),
                      32'({r5[3:0], r5[4], (s < -8 || s > 7), (r5[3:0] == 4'h0)}));
              end
            end
          end
        end
      end
    end

    // WIDTH=8 sweep, DIGIT 1/2/4/8.
    tick(); tick();
    for (int ai = 0; ai < 256; ai += 17) begin
      for (int bi = 0; bi < 256; bi += 15) begin
        for (int ci = 0; ci < 2; ci++) begin
          a8 = 8'(ai); b8 = 8'(bi); bin8 = 1'(ci); start8 = 1'b1;
          r9 = 9'(ai) - 9'(bi) - 9'(ci);
          sa = (ai >= 128) ? ai - 256 : ai;
          sb = (bi >= 128) ? bi - 256 : bi;
          s  = sa - sb - ci;
          tick();
          start8 = 1'b0;
          for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
              n = 8 >> g;
              check($sformatf("w8 d%0d %0h-%0h-%0d done@%0d", 1 << g, ai, bi, ci, cyc),
                    32'(d8_done[g]), 32'(cyc == n));
              if (cyc == n) begin
                check($sformatf("w8 d%0d %0h-%0h-%0d res", 1 << g, ai, bi, ci),
                      32'({d8_diff[g], d8_bout[g], d8_ovf[g], d8_zero[g]}),
                      32'({r9[7:0], r9[8], (s < -128 || s > 127), (r9[7:0] == 8'h00)}));
              end
            end
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
